ads41_idelay_cal: RTL and testbench

- Automatic IDELAY calibration controller for one ADS41 capture channel.
- Runs in the user clock domain. Drives the channel's idelay_val/idelay_ctrl load bus and checks the channel's de-interleaved output word while the ADC transmits a known test pattern.
- Sweeps every data lane through all 32 taps, finds the widest passing window per lane, and loads the window centre.
- Loads a fixed tap into the OVR lane, then reports per-lane pass/fail.

---
 rtl/ads41_idelay_cal.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ads41_idelay_cal.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ads41_idelay_cal.sv
// Automatic IDELAY calibration for one ADS41 capture channel: sweeps every
// data lane through all 32 taps against a known test pattern, loads the
// centre of the widest passing window, then loads a fixed tap into OVR.
module ads41_idelay_cal #(
   parameter int unsigned      NBITS         = 12,
   parameter logic [NBITS-1:0] PATTERN       = 12'hAAA,
   parameter bit               TOGGLE        = 1'b1,
   parameter int unsigned      SETTLE_CYCLES = 64,
   parameter int unsigned      CHECK_SAMPLES = 256,
   parameter int unsigned      MIN_EYE       = 4,
   parameter int unsigned      DEFAULT_TAP   = 8,
   parameter int unsigned      OVR_TAP       = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [NBITS-1:0]          d_in,
   output logic [31:0]               idelay_val,
   output logic [15:0]               idelay_ctrl,
   output logic                      busy,
   output logic                      done,
   output logic [NBITS/2-1:0]        lane_fail,
   output logic [5*(NBITS/2)-1:0]    tap_report
);

   localparam int unsigned NL   = NBITS / 2;
   localparam int unsigned LW   = (NL > 1) ? $clog2(NL) : 1;
   localparam int unsigned CMAX = (SETTLE_CYCLES > CHECK_SAMPLES) ? SETTLE_CYCLES : CHECK_SAMPLES;
   localparam int unsigned CW   = $clog2(CMAX + 1);

   typedef enum logic [3:0] {
      IDLE, LOAD, SETTLE, CHECK, NEXT_TAP, CENTER, FINAL_LOAD, NEXT_LANE, OVR_LOAD, DONE
   } state_t;

   state_t              state_q, state_d;
   logic [4:0]          tap_q, tap_d;
   logic [LW-1:0]       lane_q, lane_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                pass_q, pass_d;
   logic [1:0]          prev_q, prev_d;
   logic [5:0]          cur_len_q, cur_len_d;
   logic [4:0]          cur_start_q, cur_start_d;
   logic [5:0]          best_len_q, best_len_d;
   logic [4:0]          best_start_q, best_start_d;
   logic [4:0]          final_q, final_d;
   logic [4:0]          val_hold_q, val_hold_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic [NL-1:0]       lane_fail_q, lane_fail_d;
   logic [5*NL-1:0]     tap_report_q, tap_report_d;

   logic [1:0]          lane_bits, exp_bits;
   logic                sample_ok;
   logic [5:0]          new_len;
   logic [4:0]          new_start;
   logic [5:0]          centre_sum;
   logic [4:0]          val_out;

   // State and datapath registers; reset returns every output to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         tap_q        <= '0;
         lane_q       <= '0;
         cnt_q        <= '0;
         pass_q       <= 1'b0;
         prev_q       <= '0;
         cur_len_q    <= '0;
         cur_start_q  <= '0;
         best_len_q   <= '0;
         best_start_q <= '0;
         final_q      <= '0;
         val_hold_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         lane_fail_q  <= '0;
         tap_report_q <= '0;
      end else begin
         state_q      <= state_d;
         tap_q        <= tap_d;
         lane_q       <= lane_d;
         cnt_q        <= cnt_d;
         pass_q       <= pass_d;
         prev_q       <= prev_d;
         cur_len_q    <= cur_len_d;
         cur_start_q  <= cur_start_d;
         best_len_q   <= best_len_d;
         best_start_q <= best_start_d;
         final_q      <= final_d;
         val_hold_q   <= val_hold_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         lane_fail_q  <= lane_fail_d;
         tap_report_q <= tap_report_d;
      end
   end

   // Select the rising/falling bit pair of the lane under test and grade the sample.
   always_comb begin
      lane_bits = '0;
      exp_bits  = '0;
      for (int unsigned l = 0; l < NL; l++) begin
         if (lane_q == LW'(l)) begin
            lane_bits = d_in[2*l +: 2];
            exp_bits  = PATTERN[2*l +: 2];
         end
      end
      sample_ok = (lane_bits == exp_bits) || (lane_bits == ~exp_bits);
      if (TOGGLE && (cnt_q != '0) && (lane_bits == prev_q))
         sample_ok = 1'b0;
   end

   // Load bus: tap value shown during load cycles, otherwise the last value held.
   always_comb begin
      val_out     = val_hold_q;
      idelay_ctrl = '0;
      case (state_q)
         LOAD: begin
            val_out = tap_q;
            for (int unsigned l = 0; l < NL; l++)
               if (lane_q == LW'(l)) idelay_ctrl[l] = 1'b1;
         end
         FINAL_LOAD: begin
            val_out = final_q;
            for (int unsigned l = 0; l < NL; l++)
               if (lane_q == LW'(l)) idelay_ctrl[l] = 1'b1;
         end
         OVR_LOAD: begin
            val_out         = 5'(OVR_TAP);
            idelay_ctrl[NL] = 1'b1;
         end
         default: ;
      endcase
      val_hold_d = val_out;
   end

   // Next-state logic: tap sweep, run tracking, centring and lane sequencing.
   always_comb begin
      state_d      = state_q;
      tap_d        = tap_q;
      lane_d       = lane_q;
      cnt_d        = cnt_q;
      pass_d       = pass_q;
      prev_d       = prev_q;
      cur_len_d    = cur_len_q;
      cur_start_d  = cur_start_q;
      best_len_d   = best_len_q;
      best_start_d = best_start_q;
      final_d      = final_q;
      busy_d       = busy_q;
      done_d       = done_q;
      lane_fail_d  = lane_fail_q;
      tap_report_d = tap_report_q;

      new_len    = cur_len_q + 6'd1;
      new_start  = (cur_len_q == '0) ? tap_q : cur_start_q;
      centre_sum = {1'b0, best_start_q} + {1'b0, best_len_q[5:1]};

      case (state_q)
         IDLE: begin
            if (start) begin
               done_d       = 1'b0;
               busy_d       = 1'b1;
               lane_fail_d  = '0;
               tap_report_d = '0;
               lane_d       = '0;
               tap_d        = '0;
               cnt_d        = '0;
               cur_len_d    = '0;
               cur_start_d  = '0;
               best_len_d   = '0;
               best_start_d = '0;
               state_d      = LOAD;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = SETTLE;
         end
         SETTLE: begin
            if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = CHECK;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         CHECK: begin
            pass_d = (cnt_q == '0) ? sample_ok : (pass_q & sample_ok);
            prev_d = lane_bits;
            if (cnt_q == CW'(CHECK_SAMPLES - 1)) begin
               cnt_d   = '0;
               state_d = NEXT_TAP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         NEXT_TAP: begin
            if (pass_q) begin
               cur_len_d   = new_len;
               cur_start_d = new_start;
               // Strictly greater, so an equal later run never displaces the earlier one.
               if (new_len > best_len_q) begin
                  best_len_d   = new_len;
                  best_start_d = new_start;
               end
            end else begin
               cur_len_d = '0;
            end
            if (tap_q != 5'd31) begin
               tap_d   = tap_q + 5'd1;
               state_d = LOAD;
            end else begin
               state_d = CENTER;
            end
         end
         CENTER: begin
            if (best_len_q >= 6'(MIN_EYE)) begin
               final_d = (centre_sum > 6'd31) ? 5'd31 : centre_sum[4:0];
            end else begin
               final_d = 5'(DEFAULT_TAP);
               for (int unsigned l = 0; l < NL; l++)
                  if (lane_q == LW'(l)) lane_fail_d[l] = 1'b1;
            end
            state_d = FINAL_LOAD;
         end
         FINAL_LOAD: begin
            for (int unsigned l = 0; l < NL; l++)
               if (lane_q == LW'(l)) tap_report_d[5*l +: 5] = final_q;
            cur_len_d    = '0;
            cur_start_d  = '0;
            best_len_d   = '0;
            best_start_d = '0;
            state_d      = NEXT_LANE;
         end
         NEXT_LANE: begin
            if (lane_q != LW'(NL - 1)) begin
               lane_d  = lane_q + 1'b1;
               tap_d   = '0;
               state_d = LOAD;
            end else begin
               state_d = OVR_LOAD;
            end
         end
         OVR_LOAD: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign idelay_val = {27'd0, val_out};
   assign busy       = busy_q;
   assign done       = done_q;
   assign lane_fail  = lane_fail_q;
   assign tap_report = tap_report_q;

endmodule

// File: tb/tb_ads41_idelay_cal.sv
// Bench for ads41_idelay_cal: emulates per-lane IDELAY eyes as pass masks over
// the 32 taps and compares calibration results with a window-search model.
module tb_ads41_idelay_cal;

   localparam int NBITS      = 12;
   localparam int NL         = NBITS / 2;
   localparam int SETTLE     = 4;
   localparam int CHECK      = 8;
   localparam int MIN_EYE    = 4;
   localparam int DEF_TAP    = 8;
   localparam int OVR_TAP    = 8;
   localparam int RUN_CYCLES = NL * (32 * (2 + SETTLE + CHECK) + 3) + 1;
   localparam int N_STROBES  = NL * 33 + 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [NBITS-1:0]     d_in;
   logic [31:0]          idelay_val;
   logic [15:0]          idelay_ctrl;
   logic                 busy;
   logic                 done;
   logic [NL-1:0]        lane_fail;
   logic [5*NL-1:0]      tap_report;

   always #5 clk = ~clk;

   ads41_idelay_cal #(
      .NBITS(NBITS), .PATTERN(12'hAAA), .TOGGLE(1'b1),
      .SETTLE_CYCLES(SETTLE), .CHECK_SAMPLES(CHECK), .MIN_EYE(MIN_EYE),
      .DEFAULT_TAP(DEF_TAP), .OVR_TAP(OVR_TAP)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .d_in(d_in),
      .idelay_val(idelay_val), .idelay_ctrl(idelay_ctrl),
      .busy(busy), .done(done), .lane_fail(lane_fail), .tap_report(tap_report)
   );

   // Channel model configuration
   logic [31:0] mask [NL];
   logic        stat_lane [NL];
   logic [1:0]  fkind [NL][32];

   // Observed load-bus activity for the current run
   int lane_tap [NL];
   int lane_strobes [NL];
   int last_val [NL];
   int strobes, seq_err, busy_cycles, last_idx, last_v;

   int total = 0;
   int bad   = 0;

   // Emulated capture channel: latches taps on LD strobes, records strobe
   // order, and drives d_in per lane according to whether its tap is in the eye.
   initial begin
      logic             busy_prev, phase;
      logic [NBITS-1:0] pat_v;
      logic [1:0]       pb, b;
      int               tp;
      pat_v = 12'hAAA;
      phase = 1'b0;
      busy_prev = 1'b0;
      strobes = 0; seq_err = 0; busy_cycles = 0; last_idx = -1; last_v = -1;
      for (int l = 0; l < NL; l++) begin
         lane_tap[l] = 0; lane_strobes[l] = 0; last_val[l] = -1;
      end
      d_in = '0;
      forever begin
         @(negedge clk);
         if (busy && !busy_prev) begin
            strobes = 0; seq_err = 0; busy_cycles = 0; last_idx = -1; last_v = -1;
            for (int l = 0; l < NL; l++) begin
               lane_strobes[l] = 0; last_val[l] = -1;
            end
         end
         busy_prev = busy;
         if (busy) busy_cycles++;
         if (idelay_ctrl != 16'h0) begin
            strobes++;
            last_v = int'(idelay_val[4:0]);
            if (idelay_val[31:5] != 27'd0 || idelay_ctrl[15:NL+1] != '0 ||
                $countones(idelay_ctrl) != 1)
               seq_err++;
            for (int l = 0; l <= NL; l++) begin
               if (idelay_ctrl[l]) begin
                  last_idx = l;
                  if (l < NL) begin
                     if (lane_strobes[l] < 32 && last_v != lane_strobes[l]) seq_err++;
                     if (l > 0 && lane_strobes[l-1] != 33) seq_err++;
                     lane_strobes[l]++;
                     last_val[l] = last_v;
                     lane_tap[l] = last_v;
                  end else begin
                     for (int k = 0; k < NL; k++)
                        if (lane_strobes[k] != 33) seq_err++;
                  end
               end
            end
         end
         phase = ~phase;
         for (int l = 0; l < NL; l++) begin
            tp = lane_tap[l];
            pb = pat_v[2*l +: 2];
            if (stat_lane[l])       b = pb;
            else if (mask[l][tp])   b = phase ? ~pb : pb;
            else begin
               case (fkind[l][tp])
                  2'd0:    b = pb ^ 2'b01;
                  2'd1:    b = pb ^ 2'b10;
                  default: b = pb;
               endcase
            end
            d_in[2*l +: 2] = b;
         end
      end
   end

   function automatic logic [31:0] win(input int lo, input int hi);
      logic [31:0] r;
      r = '0;
      for (int k = lo; k <= hi; k++) r[k] = 1'b1;
      return r;
   endfunction

   // Reference: enumerate maximal passing runs, keep the first longest one.
   function automatic logic [5:0] model_lane(input logic [31:0] m, input logic st);
      int bl, bs, e, t;
      bl = 0; bs = 0;
      if (!st) begin
         for (int s = 0; s < 32; s++) begin
            if (m[s] && (s == 0 || !m[s-1])) begin
               e = s;
               while (e < 32 && m[e]) e++;
               if (e - s > bl) begin bl = e - s; bs = s; end
            end
         end
      end
      if (bl >= MIN_EYE) begin
         t = bs + bl / 2;
         if (t > 31) t = 31;
         return {1'b0, 5'(t)};
      end
      return {1'b1, 5'(DEF_TAP)};
   endfunction

   task automatic randomize_fail_kinds();
      for (int l = 0; l < NL; l++)
         for (int t = 0; t < 32; t++) fkind[l][t] = 2'($urandom_range(0, 2));
   endtask

   task automatic set_directed();
      for (int l = 0; l < NL; l++) stat_lane[l] = 1'b0;
      mask[0] = 32'hFFFF_FFFF;
      mask[1] = win(2, 5) | win(20, 27);
      mask[2] = win(10, 20);
      mask[3] = win(4, 7) | win(12, 15);
      mask[4] = 32'h0;
      mask[5] = 32'hFFFF_FFFF;
      stat_lane[5] = 1'b1;
      randomize_fail_kinds();
   endtask

   task automatic set_random();
      int nr, s, len;
      for (int l = 0; l < NL; l++) begin
         mask[l] = '0;
         nr = $urandom_range(0, 3);
         for (int r = 0; r < nr; r++) begin
            s   = $urandom_range(0, 31);
            len = $urandom_range(1, 14);
            for (int k = s; k < s + len && k < 32; k++) mask[l][k] = 1'b1;
         end
         stat_lane[l] = ($urandom_range(0, 7) == 0);
      end
      randomize_fail_kinds();
   endtask

   // Pulse start and wait (bounded) for done; optionally hit start while busy.
   task automatic run_cal(input bit spurious);
      int c;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         bad++;
         $display("FAIL start_ack: busy=%b done=%b, required busy=1 done=0", busy, done);
      end
      c = 0;
      while (done !== 1'b1 && c < 3 * RUN_CYCLES) begin
         @(negedge clk);
         c++;
         start = spurious && (c == 50 || c == 1200 || c == RUN_CYCLES - 20);
      end
      start = 1'b0;
      total++;
      if (done !== 1'b1) begin
         bad++;
         $display("FAIL run_timeout: done=%b after %0d cycles, required 1", done, c);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      set_directed();
      #12;
      total++;
      if (idelay_val !== 32'h0 || idelay_ctrl !== 16'h0 || busy !== 1'b0 || done !== 1'b0 ||
          lane_fail !== '0 || tap_report !== '0) begin
         bad++;
         $display("FAIL reset_outputs: val=%h ctrl=%h busy=%b done=%b fail=%b rep=%h, required all 0",
                  idelay_val, idelay_ctrl, busy, done, lane_fail, tap_report);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0 || idelay_ctrl !== 16'h0) begin
         bad++;
         $display("FAIL idle_after_reset: busy=%b ctrl=%h, required 0/0", busy, idelay_ctrl);
      end
   endtask

   task automatic test_directed();
      int exp_t [NL] = '{16, 24, 15, 6, 8, 8};
      logic [5*NL-1:0] exp_rep;
      set_directed();
      run_cal(1'b0);
      for (int l = 0; l < NL; l++) exp_rep[5*l +: 5] = 5'(exp_t[l]);
      total++;
      if (lane_fail !== 6'b110000) begin
         bad++;
         $display("FAIL dir_lane_fail: got %b, required 110000", lane_fail);
      end
      total++;
      if (tap_report !== exp_rep) begin
         bad++;
         $display("FAIL dir_tap_report: got %h, required %h", tap_report, exp_rep);
      end
      for (int l = 0; l < NL; l++) begin
         total++;
         if (last_val[l] != exp_t[l] || lane_strobes[l] != 33) begin
            bad++;
            $display("FAIL dir_final_load lane %0d: val=%0d strobes=%0d, required val=%0d strobes=33",
                     l, last_val[l], lane_strobes[l], exp_t[l]);
         end
      end
      total++;
      if (strobes != N_STROBES || seq_err != 0) begin
         bad++;
         $display("FAIL dir_strobes: count=%0d seq_err=%0d, required %0d/0", strobes, seq_err, N_STROBES);
      end
      total++;
      if (last_idx != NL || last_v != OVR_TAP) begin
         bad++;
         $display("FAIL dir_ovr_load: bit=%0d val=%0d, required bit=%0d val=%0d", last_idx, last_v, NL, OVR_TAP);
      end
      total++;
      if (busy_cycles != RUN_CYCLES || busy !== 1'b0 || done !== 1'b1) begin
         bad++;
         $display("FAIL dir_busy: cycles=%0d busy=%b done=%b, required %0d/0/1",
                  busy_cycles, busy, done, RUN_CYCLES);
      end
   endtask

   task automatic test_random(input int iters, input bit spurious);
      logic [5:0]      r;
      logic [5*NL-1:0] exp_rep;
      logic [NL-1:0]   exp_fail;
      for (int it = 0; it < iters; it++) begin
         set_random();
         for (int l = 0; l < NL; l++) begin
            r = model_lane(mask[l], stat_lane[l]);
            exp_rep[5*l +: 5] = r[4:0];
            exp_fail[l] = r[5];
         end
         run_cal(spurious);
         total++;
         if (tap_report !== exp_rep || lane_fail !== exp_fail) begin
            bad++;
            $display("FAIL rnd_result it=%0d: rep=%h fail=%b, required rep=%h fail=%b",
                     it, tap_report, lane_fail, exp_rep, exp_fail);
         end
         total++;
         if (strobes != N_STROBES || seq_err != 0 || last_idx != NL || last_v != OVR_TAP) begin
            bad++;
            $display("FAIL rnd_strobes it=%0d: count=%0d seq_err=%0d last=%0d/%0d, required %0d/0/%0d/%0d",
                     it, strobes, seq_err, last_idx, last_v, N_STROBES, NL, OVR_TAP);
         end
         total++;
         if (busy_cycles != RUN_CYCLES) begin
            bad++;
            $display("FAIL rnd_busy_cycles it=%0d: got %0d, required %0d", it, busy_cycles, RUN_CYCLES);
         end
      end
   endtask

   task automatic test_back_to_back();
      test_random(2, 1'b1);
   endtask

   task automatic test_reset_midrun();
      bit found;
      int exp_t [NL] = '{16, 24, 15, 6, 8, 8};
      logic [5*NL-1:0] exp_rep;
      set_directed();
      for (int l = 0; l < NL; l++) exp_rep[5*l +: 5] = 5'(exp_t[l]);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 2 * RUN_CYCLES && !found; c++) begin
         @(negedge clk);
         if (idelay_ctrl[3] && idelay_val[4:0] == 5'd9) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL midrun_find_lane3_tap9: strobe not seen, required within %0d cycles", 2 * RUN_CYCLES);
      end
      repeat (1 + SETTLE + 1) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      total++;
      if (idelay_ctrl !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || idelay_val !== 32'h0 ||
          lane_fail !== '0 || tap_report !== '0) begin
         bad++;
         $display("FAIL midrun_reset: ctrl=%h busy=%b done=%b val=%h fail=%b rep=%h, required all 0",
                  idelay_ctrl, busy, done, idelay_val, lane_fail, tap_report);
      end
      @(negedge clk);
      rst = 1'b0;
      run_cal(1'b0);
      total++;
      if (tap_report !== exp_rep || lane_fail !== 6'b110000) begin
         bad++;
         $display("FAIL midrun_rerun_result: rep=%h fail=%b, required rep=%h fail=110000",
                  tap_report, lane_fail, exp_rep);
      end
      total++;
      if (strobes != N_STROBES || seq_err != 0 || busy_cycles != RUN_CYCLES) begin
         bad++;
         $display("FAIL midrun_rerun_seq: count=%0d seq_err=%0d cycles=%0d, required %0d/0/%0d",
                  strobes, seq_err, busy_cycles, N_STROBES, RUN_CYCLES);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random(3, 1'b0);
      test_back_to_back();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
